pmod_arbiter: RTL and testbench

- Shares one 8-bit PMOD output port and the board status LED between NREQ independent pattern generators, such as counters, test-pattern sources and debug taps.
- Round-robin arbitration with a guaranteed minimum and a bounded maximum grant tenure.
- A one-cycle dead gap (output forced to 0) separates every ownership change.
- Sits between the board-top pattern sources and the PMOD_A/PMOD_B pin assignments; runs in the CLK_48 domain.

---
 rtl/pmod_arbiter.sv | 147 ++++++++++++++
 tb/tb_pmod_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pmod_arbiter.sv
// Round-robin owner of the shared PMOD port and status LED, with min/max tenure.
// Define PMOD_ARB_PREEMPT_EN to make requester 0 a priority source.
module pmod_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MIN_HOLD = 48000,
    parameter int MAX_HOLD = 4800000
) (
    input  logic                  CLK_48,
    input  logic                  RST_N,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data,
    output logic [NREQ-1:0]       grant,
    output logic [WIDTH-1:0]      PMOD_OUT,
    output logic                  LED_A,
    output logic                  switch_pulse
);

    localparam int IW = $clog2(NREQ);
    localparam int HW = $clog2(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t          state, state_n;
    logic [NREQ-1:0] grant_n;
    logic [WIDTH-1:0] pmod_n;
    logic            pulse_n;
    logic [HW-1:0]   hold_ctr, ctr_n;
    logic [IW-1:0]   last, last_n;

    logic [WIDTH-1:0] src [NREQ];
    logic [IW-1:0]   idx;
    logic [IW-1:0]   win_idx;
    logic            win_any;
    logic            own_req;
    logic            other_req;
    logic            min_ok;
    logic            at_max;
    logic            release_now;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            src[i] = data[i*WIDTH +: WIDTH];
        end
    end

    // Walk downward so the first asserted requester after last wins.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % NREQ);
            if (req[idx]) begin
                win_any = 1'b1;
                win_idx = idx;
            end
        end
`ifdef PMOD_ARB_PREEMPT_EN
        if (req[0]) begin
            win_any = 1'b1;
            win_idx = '0;
        end
`endif
    end

    assign own_req   = req[last];
    assign other_req = |(req & ~grant);
    assign min_ok    = hold_ctr >= HW'(MIN_HOLD - 1);
    assign at_max    = hold_ctr == HW'(MAX_HOLD - 1);

`ifdef PMOD_ARB_PREEMPT_EN
    assign release_now = (!own_req && min_ok) || (at_max && other_req) ||
                         (req[0] && (last != '0) && min_ok);
`else
    assign release_now = (!own_req && min_ok) || (at_max && other_req);
`endif

    always_comb begin
        state_n = state;
        grant_n = grant;
        pmod_n  = PMOD_OUT;
        pulse_n = 1'b0;
        ctr_n   = hold_ctr;
        last_n  = last;
        unique case (state)
            IDLE, GAP: begin
                pmod_n  = '0;
                grant_n = '0;
                state_n = IDLE;
                if (win_any) begin
                    state_n = GRANT;
                    grant_n = NREQ'(1) << win_idx;
                    pulse_n = 1'b1;
                    last_n  = win_idx;
                    ctr_n   = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_n = GAP;
                    grant_n = '0;
                    pmod_n  = '0;
                    ctr_n   = '0;
                end else begin
                    if (own_req) begin
                        pmod_n = src[last];
                    end
                    if (!at_max) begin
                        ctr_n = hold_ctr + HW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                pmod_n  = '0;
                ctr_n   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_48 or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            grant        <= '0;
            PMOD_OUT     <= '0;
            switch_pulse <= 1'b0;
            hold_ctr     <= '0;
            last         <= IW'(NREQ - 1);
        end else begin
            state        <= state_n;
            grant        <= grant_n;
            PMOD_OUT     <= pmod_n;
            switch_pulse <= pulse_n;
            hold_ctr     <= ctr_n;
            last         <= last_n;
        end
    end

    assign LED_A = ~|grant;

endmodule

// File: tb/tb_pmod_arbiter.sv
// Directed vector bench for pmod_arbiter (NREQ=4, WIDTH=8, MIN_HOLD=4, MAX_HOLD=16).
// Preemption sequence is compiled only when PMOD_ARB_PREEMPT_EN is defined.
module tb_pmod_arbiter;

    logic        CLK_48 = 1'b0;
    logic        RST_N;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  grant;
    logic [7:0]  PMOD_OUT;
    logic        LED_A;
    logic        switch_pulse;

    int n_vec = 0;
    int n_bad = 0;

    pmod_arbiter #(
        .NREQ(4),
        .WIDTH(8),
        .MIN_HOLD(4),
        .MAX_HOLD(16)
    ) dut (
        .CLK_48(CLK_48),
        .RST_N(RST_N),
        .req(req),
        .data(data),
        .grant(grant),
        .PMOD_OUT(PMOD_OUT),
        .LED_A(LED_A),
        .switch_pulse(switch_pulse)
    );

    always #5 CLK_48 = ~CLK_48;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  grant;
        logic [7:0]  pmod;
        logic        led;
        logic        pulse;
    } vec_t;

    vec_t tab [13];

    task automatic tick();
        @(posedge CLK_48);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [3:0] g, input logic [7:0] p,
                           input logic l, input logic s);
        chk({nm, ".grant"}, 32'(grant), 32'(g));
        chk({nm, ".pmod"}, 32'(PMOD_OUT), 32'(p));
        chk({nm, ".led"}, 32'(LED_A), 32'(l));
        chk({nm, ".pulse"}, 32'(switch_pulse), 32'(s));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        req      data          grant    pmod   led   pulse
        tab[0]  = '{4'b0001, 32'h000000A5, 4'b0001, 8'h00, 1'b0, 1'b1};
        tab[1]  = '{4'b0001, 32'h000000A5, 4'b0001, 8'hA5, 1'b0, 1'b0};
        tab[2]  = '{4'b0000, 32'h000000A5, 4'b0001, 8'hA5, 1'b0, 1'b0};
        tab[3]  = '{4'b0000, 32'h000000A5, 4'b0001, 8'hA5, 1'b0, 1'b0};
        tab[4]  = '{4'b0000, 32'h000000A5, 4'b0000, 8'h00, 1'b1, 1'b0};
        tab[5]  = '{4'b0000, 32'h000000A5, 4'b0000, 8'h00, 1'b1, 1'b0};
        tab[6]  = '{4'b0001, 32'h0000003C, 4'b0001, 8'h00, 1'b0, 1'b1};
        tab[7]  = '{4'b0000, 32'h0000003C, 4'b0001, 8'h00, 1'b0, 1'b0};
        tab[8]  = '{4'b0000, 32'h0000003C, 4'b0001, 8'h00, 1'b0, 1'b0};
        tab[9]  = '{4'b0000, 32'h0000003C, 4'b0001, 8'h00, 1'b0, 1'b0};
        tab[10] = '{4'b0000, 32'h0000003C, 4'b0000, 8'h00, 1'b1, 1'b0};
        tab[11] = '{4'b0000, 32'h0000003C, 4'b0000, 8'h00, 1'b1, 1'b0};
        tab[12] = '{4'b0000, 32'h0000003C, 4'b0000, 8'h00, 1'b1, 1'b0};

        req   = '0;
        data  = '0;
        RST_N = 1'b1;
        #2 RST_N = 1'b0;
        #1 chk_all("reset", 4'b0000, 8'h00, 1'b1, 1'b0);
        tick();
        tick();
        chk_all("reset_hold", 4'b0000, 8'h00, 1'b1, 1'b0);
        RST_N = 1'b1;

        // first grant, release at MIN_HOLD, then a one-cycle req0 pulse
        for (int i = 0; i < 13; i++) begin
            req  = tab[i].req;
            data = tab[i].data;
            tick();
            chk_all($sformatf("tab%0d", i), tab[i].grant, tab[i].pmod,
                    tab[i].led, tab[i].pulse);
        end

        // fresh reset so rotation starts at requester 0
        #2 RST_N = 1'b0;
        #1 chk_all("reset2", 4'b0000, 8'h00, 1'b1, 1'b0);
        tick();
        RST_N = 1'b1;

        req  = 4'b1111;
        data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int r = 0; r < 5; r++) begin
            automatic int o = r % 4;
            for (int c = 0; c < 16; c++) begin
                tick();
                chk($sformatf("rr%0d_c%0d.grant", r, c), 32'(grant), 32'(4'b0001 << o));
                chk($sformatf("rr%0d_c%0d.pulse", r, c), 32'(switch_pulse), (c == 0) ? 1 : 0);
                chk($sformatf("rr%0d_c%0d.pmod", r, c), 32'(PMOD_OUT),
                    (c == 0) ? 32'h0 : 32'(8'h10 + o));
            end
            if (r < 4) begin
                tick();
                chk_all($sformatf("rr%0d_gap", r), 4'b0000, 8'h00, 1'b1, 1'b0);
            end
        end

        // owner 0 saturated; dropping req gives gap then idle
        req = 4'b0000;
        tick();
        chk_all("drop_gap", 4'b0000, 8'h00, 1'b1, 1'b0);
        tick();
        chk_all("drop_idle", 4'b0000, 8'h00, 1'b1, 1'b0);

        // sole requester keeps the port past MAX_HOLD
        req = 4'b0100;
        for (int c = 0; c < 40; c++) begin
            tick();
            chk($sformatf("solo_c%0d.grant", c), 32'(grant), 32'(4'b0100));
            chk($sformatf("solo_c%0d.pmod", c), 32'(PMOD_OUT), (c == 0) ? 32'h0 : 32'h12);
        end
        req = 4'b0110;
        tick();
        chk_all("solo_gap", 4'b0000, 8'h00, 1'b1, 1'b0);
        tick();
        chk_all("solo_next", 4'b0010, 8'h00, 1'b0, 1'b1);
        tick();
        chk_all("solo_next_data", 4'b0010, 8'h11, 1'b0, 1'b0);

        // asynchronous reset in the middle of a tenure
        req = 4'b1111;
        #2 RST_N = 1'b0;
        #1 chk_all("mid_reset", 4'b0000, 8'h00, 1'b1, 1'b0);
        tick();
        RST_N = 1'b1;
        tick();
        chk_all("post_reset", 4'b0001, 8'h00, 1'b0, 1'b1);
        tick();
        chk_all("post_reset_data", 4'b0001, 8'h10, 1'b0, 1'b0);

`ifdef PMOD_ARB_PREEMPT_EN
        req = 4'b0000;
        #2 RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        req = 4'b0100;
        tick();
        chk_all("pre_own2", 4'b0100, 8'h00, 1'b0, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk($sformatf("pre_hold%0d", c), 32'(grant), 32'(4'b0100));
        end
        req = 4'b0101;
        tick();
        chk_all("pre_gap", 4'b0000, 8'h00, 1'b1, 1'b0);
        tick();
        chk_all("pre_win0", 4'b0001, 8'h00, 1'b0, 1'b1);
        req = 4'b0110;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("pre_own0_%0d", c), 32'(grant), 32'(4'b0001));
        end
        tick();
        chk_all("pre_gap2", 4'b0000, 8'h00, 1'b1, 1'b0);
        tick();
        chk_all("pre_rr1", 4'b0010, 8'h00, 1'b0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
